// File: rtl/sm_violation_pkg.sv
// sm_violation_pkg
//   Shared types for the Sancus violation handler slice:
//   - sm_state_e : handler FSM states (IDLE / HOLD / RELEASE)
//   - KIND_W     : width of the captured access-kind field
//   - KIND_*     : access-kind encodings (exec / read / write)
package sm_violation_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    RELEASE = 2'd2
  } sm_state_e;

  localparam int KIND_W = 2;

  localparam logic [KIND_W-1:0] KIND_EXEC  = 2'd0;
  localparam logic [KIND_W-1:0] KIND_READ  = 2'd1;
  localparam logic [KIND_W-1:0] KIND_WRITE = 2'd2;

endpackage

// File: rtl/sm_violation_log.sv
// sm_violation_log
//   First-fault-sticky capture bank for accepted SPM violations.
//   Only instantiated when SM_VIOLATION_LOG_EN is defined.
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   capture_i             an accepted violation on this edge
//   clr_i                 clears record and overflow flag (applied before capture)
//   pc_i, prev_pc_i       PC values to capture
//   addr_i                data address to capture
//   data_en_i, data_wr_i  data access qualifiers, decoded into the access kind
//   valid_o, ovf_o        record held / violation accepted while a record was held
//   pc_o, prev_pc_o, addr_o, kind_o  captured record
module sm_violation_log
  import sm_violation_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              capture_i,
  input  logic              clr_i,
  input  logic [15:0]       pc_i,
  input  logic [15:0]       prev_pc_i,
  input  logic [15:0]       addr_i,
  input  logic              data_en_i,
  input  logic              data_wr_i,
  output logic              valid_o,
  output logic              ovf_o,
  output logic [15:0]       pc_o,
  output logic [15:0]       prev_pc_o,
  output logic [15:0]       addr_o,
  output logic [KIND_W-1:0] kind_o
);

  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d;
  logic [15:0]       pc_q, pc_d;
  logic [15:0]       prev_pc_q, prev_pc_d;
  logic [15:0]       addr_q, addr_d;
  logic [KIND_W-1:0] kind_q, kind_d;
  logic [KIND_W-1:0] kind_now;

  // Access kind of the instruction that tripped the violation.
  always_comb begin
    kind_now = KIND_EXEC;
    if (data_en_i && data_wr_i) begin
      kind_now = KIND_WRITE;
    end else if (data_en_i) begin
      kind_now = KIND_READ;
    end
  end

  // Clear is evaluated first so that a coincident clear + capture
  // leaves a fresh record with the overflow flag low.
  always_comb begin
    valid_d   = valid_q;
    ovf_d     = ovf_q;
    pc_d      = pc_q;
    prev_pc_d = prev_pc_q;
    addr_d    = addr_q;
    kind_d    = kind_q;
    if (clr_i) begin
      valid_d   = 1'b0;
      ovf_d     = 1'b0;
      pc_d      = '0;
      prev_pc_d = '0;
      addr_d    = '0;
      kind_d    = KIND_EXEC;
    end
    if (capture_i) begin
      if (!valid_d) begin
        valid_d   = 1'b1;
        pc_d      = pc_i;
        prev_pc_d = prev_pc_i;
        addr_d    = addr_i;
        kind_d    = kind_now;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  // Record registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
      pc_q      <= '0;
      prev_pc_q <= '0;
      addr_q    <= '0;
      kind_q    <= KIND_EXEC;
    end else begin
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
      pc_q      <= pc_d;
      prev_pc_q <= prev_pc_d;
      addr_q    <= addr_d;
      kind_q    <= kind_d;
    end
  end

  assign valid_o   = valid_q;
  assign ovf_o     = ovf_q;
  assign pc_o      = pc_q;
  assign prev_pc_o = prev_pc_q;
  assign addr_o    = addr_q;
  assign kind_o    = kind_q;

endmodule

// File: rtl/sm_violation_handler.sv
// sm_violation_handler
//   Turns the SPM control's violation flag into a stretched, registered
//   reset request for the openMSP430 PUC logic, followed by a hold-off
//   window in which further violations are ignored. Counts accepted
//   violations (saturating) and, when SM_VIOLATION_LOG_EN is defined,
//   keeps a first-fault-sticky record of the offending access.
// Ports:
//   mclk, reset_n            clock, asynchronous active-low reset
//   violation                level-sampled violation flag
//   pc, prev_pc, data_addr   context captured into the log
//   data_en, data_wr         access qualifiers (kind decode)
//   log_clr                  clears the log record and overflow flag
//   puc_rst_req              registered reset request
//   busy                     FSM not in IDLE
//   viol_count               saturating count of accepted violations
//   log_valid, log_ovf, log_pc, log_prev_pc, log_addr, log_kind  log record
// Configuration macro: SM_VIOLATION_LOG_EN (log outputs tied low when undefined).
module sm_violation_handler
  import sm_violation_pkg::*;
#(
  parameter int RST_CYCLES     = 16,
  parameter int HOLDOFF_CYCLES = 4,
  parameter int CNT_W          = 8
) (
  input  logic             mclk,
  input  logic             reset_n,
  input  logic             violation,
  input  logic [15:0]      pc,
  input  logic [15:0]      prev_pc,
  input  logic [15:0]      data_addr,
  input  logic             data_en,
  input  logic             data_wr,
  input  logic             log_clr,
  output logic             puc_rst_req,
  output logic             busy,
  output logic [CNT_W-1:0] viol_count,
  output logic             log_valid,
  output logic             log_ovf,
  output logic [15:0]      log_pc,
  output logic [15:0]      log_prev_pc,
  output logic [15:0]      log_addr,
  output logic [1:0]       log_kind
);

  localparam int MAX_LOAD = (RST_CYCLES > HOLDOFF_CYCLES) ? RST_CYCLES : HOLDOFF_CYCLES;
  localparam int TW       = $clog2(MAX_LOAD + 1);
  localparam logic [TW-1:0] RST_LOAD  = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] HOLD_LOAD = (HOLDOFF_CYCLES > 0) ? TW'(HOLDOFF_CYCLES - 1) : '0;

  sm_state_e        state_q, state_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic             puc_q, puc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             accept;

  // Next-state logic. The edge that ends the hold-off window behaves like
  // an IDLE edge, so a still-pending violation is accepted exactly
  // RST_CYCLES + HOLDOFF_CYCLES edges after the previous one.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (violation) begin
          accept  = 1'b1;
          state_d = HOLD;
          tmr_d   = RST_LOAD;
        end
      end
      HOLD: begin
        if (tmr_q != '0) begin
          tmr_d = tmr_q - TW'(1);
        end else if (HOLDOFF_CYCLES > 0) begin
          state_d = RELEASE;
          tmr_d   = HOLD_LOAD;
        end else if (violation) begin
          accept = 1'b1;
          tmr_d  = RST_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      RELEASE: begin
        if (tmr_q != '0) begin
          tmr_d = tmr_q - TW'(1);
        end else if (violation) begin
          accept  = 1'b1;
          state_d = HOLD;
          tmr_d   = RST_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        tmr_d   = '0;
      end
    endcase
  end

  // Reset request is a flop copy of "next state is HOLD" so it rises on
  // the accepting edge and never glitches.
  always_comb begin
    puc_d   = (state_d == HOLD);
    count_d = count_q;
    if (accept && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // FSM, timer, reset-request and violation-count registers.
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      puc_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      puc_q   <= puc_d;
      count_q <= count_d;
    end
  end

  assign puc_rst_req = puc_q;
  assign busy        = (state_q != IDLE);
  assign viol_count  = count_q;

`ifdef SM_VIOLATION_LOG_EN
  sm_violation_log u_log (
    .clk_i     (mclk),
    .rst_ni    (reset_n),
    .capture_i (accept),
    .clr_i     (log_clr),
    .pc_i      (pc),
    .prev_pc_i (prev_pc),
    .addr_i    (data_addr),
    .data_en_i (data_en),
    .data_wr_i (data_wr),
    .valid_o   (log_valid),
    .ovf_o     (log_ovf),
    .pc_o      (log_pc),
    .prev_pc_o (log_prev_pc),
    .addr_o    (log_addr),
    .kind_o    (log_kind)
  );
`else
  assign log_valid   = 1'b0;
  assign log_ovf     = 1'b0;
  assign log_pc      = '0;
  assign log_prev_pc = '0;
  assign log_addr    = '0;
  assign log_kind    = '0;

  // Log context inputs have no consumer in this build.
  logic unused_log_inputs;
  assign unused_log_inputs = ^{log_clr, pc, prev_pc, data_addr, data_en, data_wr};
`endif

endmodule

// File: tb/tb_sm_violation_handler.sv
// tb_sm_violation_handler
//   Self-checking bench for sm_violation_handler. Two instances share the
//   stimulus: the default configuration (16/4/8) and a small one
//   (RST_CYCLES=3, HOLDOFF_CYCLES=0, CNT_W=2) for saturation and zero hold-off.
//   Log expectations depend on SM_VIOLATION_LOG_EN.
module tb_sm_violation_handler;

  logic        mclk;
  logic        resetN;
  logic        viol;
  logic [15:0] pcIn, prevPc, dataAddr;
  logic        dataEn, dataWr, logClr;

  logic        pucRstReq, busy, logValid, logOvf;
  logic [7:0]  violCount;
  logic [15:0] logPc, logPrevPc, logAddr;
  logic [1:0]  logKind;

  logic        satPuc, satBusy, satLogValid, satLogOvf;
  logic [1:0]  satCount;
  logic [15:0] satLogPc, satLogPrevPc, satLogAddr;
  logic [1:0]  satLogKind;

  int checks = 0;
  int passes = 0;
  bit armed  = 0;

  sm_violation_handler #(.RST_CYCLES(16), .HOLDOFF_CYCLES(4), .CNT_W(8)) dut (
    .mclk(mclk), .reset_n(resetN), .violation(viol), .pc(pcIn), .prev_pc(prevPc),
    .data_addr(dataAddr), .data_en(dataEn), .data_wr(dataWr), .log_clr(logClr),
    .puc_rst_req(pucRstReq), .busy(busy), .viol_count(violCount),
    .log_valid(logValid), .log_ovf(logOvf), .log_pc(logPc), .log_prev_pc(logPrevPc),
    .log_addr(logAddr), .log_kind(logKind)
  );

  sm_violation_handler #(.RST_CYCLES(3), .HOLDOFF_CYCLES(0), .CNT_W(2)) dutSat (
    .mclk(mclk), .reset_n(resetN), .violation(viol), .pc(pcIn), .prev_pc(prevPc),
    .data_addr(dataAddr), .data_en(dataEn), .data_wr(dataWr), .log_clr(logClr),
    .puc_rst_req(satPuc), .busy(satBusy), .viol_count(satCount),
    .log_valid(satLogValid), .log_ovf(satLogOvf), .log_pc(satLogPc), .log_prev_pc(satLogPrevPc),
    .log_addr(satLogAddr), .log_kind(satLogKind)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  // Reference model: an acceptance is allowed once RST+HOLDOFF edges have
  // passed since the previous one; reset request / busy are derived from
  // the distance to the latest acceptance.
  int edgeCnt = 0;
  int lastAcc [2] = '{0, 0};
  bit hasAcc [2] = '{0, 0};
  int mCount [2] = '{0, 0};
  bit expPuc [2] = '{0, 0};
  bit expBusy [2] = '{0, 0};
  bit mValid = 0, mOvf = 0;
  logic [15:0] mPc = 0, mPrev = 0, mAddr = 0;
  logic [1:0]  mKind = 0;

  always @(posedge mclk or negedge resetN) begin
    int rc, hc, mx;
    bit acc0, acc;
    if (!resetN) begin
      for (int i = 0; i < 2; i++) begin
        hasAcc[i] = 0; mCount[i] = 0; expPuc[i] = 0; expBusy[i] = 0;
      end
      mValid = 0; mOvf = 0; mPc = 0; mPrev = 0; mAddr = 0; mKind = 0;
    end else begin
      edgeCnt++;
      acc0 = 0;
      for (int i = 0; i < 2; i++) begin
        rc = (i == 0) ? 16 : 3;
        hc = (i == 0) ? 4 : 0;
        mx = (i == 0) ? 255 : 3;
        acc = viol && (!hasAcc[i] || (edgeCnt - lastAcc[i] >= rc + hc));
        if (acc) begin
          lastAcc[i] = edgeCnt;
          hasAcc[i]  = 1;
          if (mCount[i] < mx) mCount[i]++;
        end
        if (i == 0) acc0 = acc;
        expPuc[i]  = hasAcc[i] && (edgeCnt - lastAcc[i] < rc);
        expBusy[i] = hasAcc[i] && (edgeCnt - lastAcc[i] < rc + hc);
      end
      if (logClr) begin
        mValid = 0; mOvf = 0; mPc = 0; mPrev = 0; mAddr = 0; mKind = 0;
      end
      if (acc0) begin
        if (!mValid) begin
          mValid = 1; mPc = pcIn; mPrev = prevPc; mAddr = dataAddr;
          mKind = (dataEn && dataWr) ? 2'd2 : (dataEn ? 2'd1 : 2'd0);
        end else begin
          mOvf = 1;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Every-cycle comparison against the model, away from the rising edge.
  always @(negedge mclk) begin
    if (armed) begin
      checkOutput("puc", 32'(pucRstReq), 32'(expPuc[0]));
      checkOutput("busy", 32'(busy), 32'(expBusy[0]));
      checkOutput("count", 32'(violCount), 32'(mCount[0]));
      checkOutput("satPuc", 32'(satPuc), 32'(expPuc[1]));
      checkOutput("satBusy", 32'(satBusy), 32'(expBusy[1]));
      checkOutput("satCount", 32'(satCount), 32'(mCount[1]));
`ifdef SM_VIOLATION_LOG_EN
      checkOutput("logValid", 32'(logValid), 32'(mValid));
      checkOutput("logOvf", 32'(logOvf), 32'(mOvf));
      checkOutput("logPc", 32'(logPc), 32'(mPc));
      checkOutput("logPrevPc", 32'(logPrevPc), 32'(mPrev));
      checkOutput("logAddr", 32'(logAddr), 32'(mAddr));
      checkOutput("logKind", 32'(logKind), 32'(mKind));
`else
      checkOutput("logTied", 32'({logValid, logOvf, logKind}), 32'(0));
      checkOutput("logFieldsTied", 32'(logPc | logPrevPc | logAddr), 32'(0));
`endif
    end
  end

  task automatic applyStimulus(input bit v, input logic [15:0] p, input logic [15:0] pp,
                               input logic [15:0] a, input bit en, input bit wr, input bit clr);
    @(negedge mclk);
    #1;
    viol = v; pcIn = p; prevPc = pp; dataAddr = a; dataEn = en; dataWr = wr; logClr = clr;
  endtask

  task automatic idleCycle();
    applyStimulus(0, 16'h0, 16'h0, 16'h0, 0, 0, 0);
  endtask

  task automatic waitIdle();
    for (int k = 0; k < 100; k++) begin
      if (!busy && !satBusy) return;
      idleCycle();
    end
    checkOutput("waitIdleTimeout", 32'({busy, satBusy}), 32'(0));
  endtask

  initial begin
    int pucHigh, busyHigh, firstInc, secondInc, prevCnt;
    resetN = 1; viol = 0; pcIn = 0; prevPc = 0; dataAddr = 0;
    dataEn = 0; dataWr = 0; logClr = 0;
    #3 resetN = 0;
    armed = 1;
    repeat (2) @(negedge mclk);
    #1;
    checkOutput("resetPuc", 32'(pucRstReq), 32'(0));
    checkOutput("resetBusy", 32'(busy), 32'(0));
    checkOutput("resetCount", 32'(violCount), 32'(0));
    checkOutput("resetLog", 32'({logValid, logOvf, logKind}), 32'(0));
    resetN = 1;

    // Single exec violation
    idleCycle();
    applyStimulus(1, 16'hA010, 16'h9F00, 16'h1234, 0, 0, 0);
    pucHigh = 0; busyHigh = 0;
    for (int i = 0; i < 30; i++) begin
      idleCycle();
      if (pucRstReq) pucHigh++;
      if (busy) busyHigh++;
    end
    checkOutput("pucCycles", 32'(pucHigh), 32'(16));
    checkOutput("busyCycles", 32'(busyHigh), 32'(20));
    checkOutput("countAfterOne", 32'(violCount), 32'(1));
`ifdef SM_VIOLATION_LOG_EN
    checkOutput("execKind", 32'(logKind), 32'(0));
    checkOutput("execPc", 32'(logPc), 32'h0000A010);
    checkOutput("execPrevPc", 32'(logPrevPc), 32'h00009F00);
`endif

    // Hold-off masking with violation held high
    waitIdle();
    firstInc = -1; secondInc = -1; prevCnt = int'(violCount);
    for (int i = 0; i < 45; i++) begin
      applyStimulus(1, 16'hB000, 16'hAFFE, 16'h0200, 1, 0, 0);
      if (int'(violCount) != prevCnt) begin
        if (firstInc < 0) firstInc = i;
        else if (secondInc < 0) secondInc = i;
        prevCnt = int'(violCount);
      end
    end
    checkOutput("acceptGap", 32'(secondInc - firstInc), 32'(20));
`ifdef SM_VIOLATION_LOG_EN
    checkOutput("holdOvf", 32'(logOvf), 32'(1));
    checkOutput("holdFirstPc", 32'(logPc), 32'h0000A010);
`endif
    idleCycle();
    waitIdle();

    // Write violation, then clear coincident with a later acceptance
    applyStimulus(0, 16'h0, 16'h0, 16'h0, 0, 0, 1);
    applyStimulus(1, 16'hC000, 16'hC0FE, 16'h0600, 1, 1, 0);
    idleCycle();
`ifdef SM_VIOLATION_LOG_EN
    checkOutput("writeKind", 32'(logKind), 32'(2));
    checkOutput("writeAddr", 32'(logAddr), 32'h00000600);
    checkOutput("writeOvf", 32'(logOvf), 32'(0));
`endif
    waitIdle();
    applyStimulus(1, 16'hD000, 16'hD0FE, 16'h0650, 1, 0, 0);
    idleCycle();
    waitIdle();
    applyStimulus(1, 16'hE000, 16'hE0FE, 16'h0700, 1, 0, 1);
    idleCycle();
`ifdef SM_VIOLATION_LOG_EN
    checkOutput("clrValid", 32'(logValid), 32'(1));
    checkOutput("clrOvf", 32'(logOvf), 32'(0));
    checkOutput("clrAddr", 32'(logAddr), 32'h00000700);
    checkOutput("clrKind", 32'(logKind), 32'(1));
`endif
    waitIdle();

    // Randomised traffic
    for (int i = 0; i < 1500; i++) begin
      applyStimulus($urandom_range(0, 7) == 0, 16'($urandom), 16'($urandom), 16'($urandom),
                    1'($urandom), 1'($urandom), $urandom_range(0, 15) == 0);
    end
    idleCycle();
    waitIdle();
    checkOutput("satCountSaturated", 32'(satCount), 32'(3));

    // Asynchronous reset five cycles into HOLD
    applyStimulus(1, 16'hF000, 16'hF0FE, 16'h0800, 0, 0, 0);
    repeat (5) idleCycle();
    @(posedge mclk);
    #2 resetN = 0;
    #1;
    checkOutput("asyncPuc", 32'(pucRstReq), 32'(0));
    checkOutput("asyncBusy", 32'(busy), 32'(0));
    checkOutput("asyncCount", 32'(violCount), 32'(0));
    checkOutput("asyncLog", 32'(logValid), 32'(0));
    @(negedge mclk);
    #1 resetN = 1;
    repeat (3) idleCycle();
    checkOutput("idleAfterReset", 32'(busy), 32'(0));
    applyStimulus(1, 16'h1111, 16'h2222, 16'h3333, 1, 1, 0);
    repeat (25) idleCycle();
    checkOutput("countAfterReset", 32'(violCount), 32'(1));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/sm_violation_handler.md
# sm_violation_handler

Consumer end of the Sancus access-violation path. The SPM control logic asserts `violation` on an illegal execute, read or write. This block accepts that event and, if enabled, records it. It then drives a stretched, registered reset request into the openMSP430 PUC logic, followed by a hold-off window so the restarting core is not re-flagged. It sits between the SPM control's `violation` output and the core's reset-request input, replacing a direct combinational tie.

## Interface
Parameters:
- `RST_CYCLES`, 16: cycles `puc_rst_req` is held high per accepted violation (≥1).
- `HOLDOFF_CYCLES`, 4: cycles after reset release during which violations are ignored (≥0).
- `CNT_W`, 8: width of the saturating violation counter.

Ports:
- `mclk`  in  1  system clock; all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `violation`  in  1  violation flag from SPM control, level-sampled.
- `pc`  in  16  current instruction PC.
- `prev_pc`  in  16  previous instruction PC.
- `data_addr`  in  16  data memory address bus.
- `data_en`  in  1  data access enable.
- `data_wr`  in  1  data access is a write.
- `log_clr`  in  1  single-cycle strobe; clears log record and overflow flag.
- `puc_rst_req`  out  1  registered reset request to the PUC generator.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `viol_count`  out  CNT_W  accepted violations, saturating at all-ones.
- `log_valid`  out  1  a record is held.
- `log_ovf`  out  1  a violation was accepted while `log_valid` was already 1.
- `log_pc`, `log_prev_pc`, `log_addr`  out  16 each  captured `pc`, `prev_pc` and `data_addr`.
- `log_kind`  out  2  captured access kind: 0 exec, 1 read, 2 write.

## Operation
- FSM states: IDLE, HOLD, RELEASE.
- In IDLE, `violation`=1 at an edge is an accepted violation. On that edge:
  - go to HOLD and load the down-counter with `RST_CYCLES-1`;
  - `viol_count` increments, saturating.
- HOLD: `puc_rst_req`=1. The counter decrements each cycle. At 0:
  - go to RELEASE with the counter loaded to `HOLDOFF_CYCLES-1`;
  - if `HOLDOFF_CYCLES`=0, go straight to IDLE.
- RELEASE: `puc_rst_req`=0; `violation` is ignored. At 0, go to IDLE.
- Violations in HOLD or RELEASE are dropped: no count, no log, no ovf.
- Kind encoding: `data_en&data_wr` gives 2; `data_en&~data_wr` gives 1; otherwise 0.
- Log capture is first-fault-sticky, on an accepted violation:
  - if `log_valid`=0, capture all fields and set `log_valid`;
  - otherwise set `log_ovf` and leave the record unchanged.
- `log_clr` and an accepted violation on the same edge: the clear applies first, then the capture. Result: `log_valid`=1 with new fields, `log_ovf`=0.
- `log_clr` is honoured in every state.
- `viol_count` is cleared only by `reset_n`, never by `log_clr`.

## Timing
- Reset values: state IDLE; `puc_rst_req`=0, `busy`=0, `viol_count`=0, `log_valid`=0, `log_ovf`=0; all `log_*` fields 0.
- Latency: a violation sampled at edge N gives `puc_rst_req` high from edge N to edge N+`RST_CYCLES`. That is exactly `RST_CYCLES` cycles, glitch-free, driven from a flop.
- The earliest next accepted violation is at edge N+`RST_CYCLES`+`HOLDOFF_CYCLES`.
- Log fields and `viol_count` update on the same edge as acceptance.
- Asserting `reset_n` mid-HOLD drops `puc_rst_req` immediately (asynchronously) and discards the record.
- Counter width: `$clog2(max(RST_CYCLES,HOLDOFF_CYCLES)+1)`.
- Saturation: `viol_count` at 2^CNT_W−1 stays there.

## Configuration
- `SM_VIOLATION_LOG_EN` defined: full log logic as above.
- Not defined:
  - `log_valid`, `log_ovf`, `log_pc`, `log_prev_pc`, `log_addr` and `log_kind` are tied to 0;
  - `log_clr` is ignored; no log flops are synthesised.
  - FSM, `puc_rst_req` and `viol_count` are unchanged.

## Structure
- Package `sm_violation_pkg` holds:
  - the state enum (IDLE/HOLD/RELEASE);
  - kind localparams `KIND_EXEC`/`KIND_READ`/`KIND_WRITE`;
  - kind width 2.
- Sub-module `sm_violation_log`: the capture register bank, the kind decode, the clear/capture priority and `log_ovf`. It is instantiated only under `SM_VIOLATION_LOG_EN`.
- FSM, down-counter and violation counter stay in the top module.

## Test plan
- **Reset:** deassert `reset_n` → all outputs 0, `busy`=0.
- **Single exec violation, defaults:**
  - Stimulus: `violation` pulse with `pc`=A010, `prev_pc`=9F00, `data_en`=0.
  - `puc_rst_req` is high exactly 16 cycles starting the next cycle; `busy` is high for 20 cycles.
  - `log_kind`=0, `log_pc`=A010, `viol_count`=1.
- **Hold-off masking:**
  - Stimulus: hold `violation` high continuously.
  - A second acceptance occurs at cycle 20 after the first, not earlier.
  - `log_ovf`=1; the record still holds the first fault.
- **Write violation plus clear:**
  - Stimulus: `data_en`=1, `data_wr`=1, `data_addr`=0600.
  - `log_kind`=2, `log_addr`=0600.
  - `log_clr` coincident with the next acceptance → new record, `log_ovf`=0.
- **Saturation:** with `CNT_W`=2, 5 accepted violations → `viol_count`=3.
- **Async reset mid-HOLD:** drop `reset_n` 5 cycles into HOLD → `puc_rst_req`=0 immediately; state IDLE after release.
